mem_rd_arbiter: RTL and testbench
=================================

# mem_rd_arbiter

Arbitrates the single BANDWIDTH-wide external-memory read port among three loaders: feature data (0), weights (1) and bias (2). It issues burst read commands and tracks up to four outstanding bursts in a tag queue. It steers in-order return beats to the owning loader with a one-hot valid. Runs entirely in clk_data, upstream of the data reorder/FIFO path and the weight/bias reload logic.

## Interface
- BANDWIDTH, 512, width of a memory beat
- ADDR_W, 32, byte-address width
- LEN_W, 8, burst length field width (beats minus 1)
- OUTS, 4, maximum outstanding bursts (tag queue depth)
- Reset is rst_n, asynchronous, active-low; the clock is clk_data.
- clk_data  in  1  block clock
- rst_n  in  1  async active-low reset
- req_valid  in  3  per-requester burst request; held until req_ready
- req_addr  in  3*ADDR_W  per-requester start address, slice i at [i*ADDR_W +: ADDR_W]
- req_len  in  3*LEN_W  per-requester beats-1
- req_stall  in  3  per-requester throttle (feature FIFO near-full, etc.); blocks new grants only
- req_ready  out  3  one-cycle grant pulse
- mem_cmd_valid  out  1  command valid
- mem_cmd_ready  in  1  command accept
- mem_cmd_addr  out  ADDR_W  command address
- mem_cmd_len  out  LEN_W  command beats-1
- mem_rd_data  in  BANDWIDTH  return beat
- mem_rd_vld  in  1  return beat valid; never stalled
- rd_data  out  BANDWIDTH  registered return beat
- rd_vld  out  3  one-hot owner of rd_data
- burst_done  out  3  one-hot pulse with last beat of a burst
- rsp_err  out  1  sticky: beat arrived with tag queue empty

## Operation
- FSM states:
  - IDLE: eligible = req_valid & ~req_stall.
    - If eligible != 0 and the tag queue is not full, pick a winner, latch its addr/len/id, and go to CMD.
    - If eligible == 0 or the queue is full, stay in IDLE.
  - CMD: mem_cmd_valid=1.
    - On mem_cmd_ready, push {id,len} into the tag queue.
    - Set rr_ptr = (id+1) mod 3.
    - Return to IDLE.
- Arbitration: round-robin starting at rr_ptr, searching upward mod 3.
- req_ready[id] pulses in the first CMD cycle only.
- Requesters drop or replace req_valid after req_ready. No new grant is made while in CMD.
- Return path:
  - beat_cnt (LEN_W bits) counts beats of the head tag.
  - On mem_rd_vld with the queue non-empty:
    - rd_data <= mem_rd_data.
    - rd_vld <= onehot(head.id).
  - If beat_cnt == head.len: burst_done <= onehot(head.id), pop the head, beat_cnt <= 0. Otherwise beat_cnt++.
  - On mem_rd_vld with the queue empty: drop the beat, set rsp_err, and leave rd_vld at 0.
- A tag push and pop in the same cycle are both honoured; occupancy is unchanged.
- A tag queue full with OUTS entries blocks grants until a pop. A pop in cycle N allows a grant decision in N+1.
- req_len=0 is a 1-beat burst; req_len=2^LEN_W-1 is 256 beats. beat_cnt never wraps past len.
- Reset values: req_ready=0, mem_cmd_valid=0, mem_cmd_addr=0, mem_cmd_len=0, rd_data=0, rd_vld=0, burst_done=0, rsp_err=0; FSM=IDLE, rr_ptr=0, tag queue empty, beat_cnt=0.
- Reset mid-operation: everything clears immediately. Beats still returning from memory after reset raise rsp_err.

## Timing
- Grant latency: eligible in IDLE at edge N → mem_cmd_valid and req_ready at N+1.
- Back-to-back commands: one command per 2 cycles minimum (CMD → IDLE → CMD).
- mem_cmd_* is stable while mem_cmd_valid=1 and mem_cmd_ready=0.
- Return latency: mem_rd_vld at edge N → rd_data/rd_vld at N+1; burst_done shares the last beat's cycle.
- req_stall is sampled only in IDLE. Stall asserted after a grant does not cancel the grant or its data.

## Configuration
- WEIGHT_PRIO_EN
  - Defined: requester 1 (weights), if eligible, wins strict priority over round-robin. rr_ptr still advances past the winner.
  - Undefined: pure round-robin for all three requesters.

## Structure
- Package mem_rd_pkg holds:
  - requester index constants REQ_DATA=0, REQ_W=1, REQ_B=2
  - NREQ=3
  - FSM state enum {IDLE, CMD}
  - tag struct {id[1:0], len[LEN_W-1:0]}
- Sub-module rd_tag_fifo: synchronous FIFO, depth OUTS, with push/pop/full/empty and simultaneous push+pop support.

## Test plan
- Single request: req_valid=3'b001, addr 0x1000, len 3, no stall → req_ready[0] and mem_cmd_valid at +1 cycle; 4 returned beats give rd_vld=001 ×4, burst_done[0] on the 4th.
- Round-robin: all three valid continuously, len 0 → grant order 0,1,2,0; each cmd addr matches its requester.
- Stall: req_valid=111, req_stall=001 → grants alternate 1,2; releasing the stall resumes 0 at its rr turn.
- Backpressure and full: mem_cmd_ready held low 5 cycles → cmd held stable. With 4 outstanding and no returns, the 5th grant is blocked until the first burst_done, then issues one cycle later.
- Ordering/errors: interleave len 1 (data) and len 0 (bias) bursts → rd_vld follows command order. An extra beat with the queue empty sets rsp_err=1 and produces no rd_vld.
- WEIGHT_PRIO_EN defined, req_valid=111 continuously → requester 1 wins every grant. Drop req_valid[1] → falls back to round-robin 2,0.

Source files
------------

// File: rtl/mem_rd_pkg.sv
// Shared types for the external-memory read arbiter: requester ids, FSM states,
// and the outstanding-burst tag.
package mem_rd_pkg;

  localparam int NREQ      = 3;
  localparam int REQ_DATA  = 0;
  localparam int REQ_W     = 1;
  localparam int REQ_B     = 2;
  localparam int TAG_LEN_W = 8;

  typedef enum logic {IDLE, CMD} state_e;

  typedef struct packed {
    logic [1:0]           id;
    logic [TAG_LEN_W-1:0] len;
  } tag_t;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] id);
    return NREQ'(1) << id;
  endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// Tag queue for in-flight bursts; head is visible combinationally on dout.
// Simultaneous push and pop are both honoured, including when full.
module rd_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk_data,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_data) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter for the shared memory read port with in-order return steering.
// Define WEIGHT_PRIO_EN to give the weight loader strict priority over round-robin.
module mem_rd_arbiter import mem_rd_pkg::*; #(
  parameter int BANDWIDTH = 512,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = TAG_LEN_W,
  parameter int OUTS      = 4
) (
  input  logic                   clk_data,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  input  logic [NREQ-1:0]        req_stall,
  output logic [NREQ-1:0]        req_ready,
  output logic                   mem_cmd_valid,
  input  logic                   mem_cmd_ready,
  output logic [ADDR_W-1:0]      mem_cmd_addr,
  output logic [LEN_W-1:0]       mem_cmd_len,
  input  logic [BANDWIDTH-1:0]   mem_rd_data,
  input  logic                   mem_rd_vld,
  output logic [BANDWIDTH-1:0]   rd_data,
  output logic [NREQ-1:0]        rd_vld,
  output logic [NREQ-1:0]        burst_done,
  output logic                   rsp_err
);
  state_e            state, state_nxt;
  logic [1:0]        rr_ptr, win_id, cmd_id, idx;
  logic [2:0]        sum;
  logic              win_vld, grant, push, pop, last_beat;
  logic              tag_full, tag_empty;
  logic [NREQ-1:0]   eligible;
  logic [ADDR_W-1:0] addr_a [NREQ];
  logic [LEN_W-1:0]  len_a  [NREQ];
  logic [LEN_W-1:0]  beat_cnt;
  tag_t              head, push_tag;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign len_a[i]  = req_len[i*LEN_W +: LEN_W];
  end

  assign eligible = req_valid & ~req_stall;

  // First eligible requester at or above rr_ptr, wrapping mod NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + 3'(k);
      idx = (sum >= 3'(NREQ)) ? 2'(sum - 3'(NREQ)) : sum[1:0];
      if (!win_vld && eligible[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
`ifdef WEIGHT_PRIO_EN
    if (eligible[REQ_W]) begin
      win_vld = 1'b1;
      win_id  = 2'(REQ_W);
    end
`endif
  end

  assign grant = (state == IDLE) && win_vld && !tag_full;

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: if (grant) state_nxt = CMD;
      CMD: if (mem_cmd_ready) begin
        state_nxt = IDLE;
        push      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_cmd_valid = (state == CMD);

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      req_ready    <= '0;
      mem_cmd_addr <= '0;
      mem_cmd_len  <= '0;
      cmd_id       <= '0;
      rr_ptr       <= '0;
    end else begin
      req_ready <= '0;
      if (grant) begin
        req_ready    <= onehot(win_id);
        mem_cmd_addr <= addr_a[win_id];
        mem_cmd_len  <= len_a[win_id];
        cmd_id       <= win_id;
      end
      if (push) rr_ptr <= (cmd_id == 2'(NREQ-1)) ? '0 : cmd_id + 2'd1;
    end
  end

  assign push_tag  = '{id: cmd_id, len: TAG_LEN_W'(mem_cmd_len)};
  assign last_beat = (beat_cnt == LEN_W'(head.len));
  assign pop       = mem_rd_vld && !tag_empty && last_beat;

  rd_tag_fifo #(.DEPTH(OUTS), .W($bits(tag_t))) u_tag_fifo (
    .clk_data (clk_data),
    .rst_n    (rst_n),
    .push     (push),
    .din      (push_tag),
    .pop      (pop),
    .dout     (head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // Return beats are never stalled; a beat with no tag to own it is dropped.
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      rd_data    <= '0;
      rd_vld     <= '0;
      burst_done <= '0;
      rsp_err    <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      rd_vld     <= '0;
      burst_done <= '0;
      if (mem_rd_vld) begin
        if (tag_empty) begin
          rsp_err <= 1'b1;
        end else begin
          rd_data <= mem_rd_data;
          rd_vld  <= onehot(head.id);
          if (last_beat) begin
            burst_done <= onehot(head.id);
            beat_cnt   <= '0;
          end else begin
            beat_cnt <= beat_cnt + LEN_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter; expected grant orders switch on WEIGHT_PRIO_EN.
module tb_mem_rd_arbiter;
  logic         clk_data = 1'b0;
  logic         rst_n;
  logic [2:0]   req_valid, req_stall, req_ready;
  logic [95:0]  req_addr;
  logic [23:0]  req_len;
  logic         mem_cmd_valid, mem_cmd_ready;
  logic [31:0]  mem_cmd_addr;
  logic [7:0]   mem_cmd_len;
  logic [511:0] mem_rd_data, rd_data;
  logic         mem_rd_vld;
  logic [2:0]   rd_vld, burst_done;
  logic         rsp_err;

  logic [31:0]  ta [3];
  logic [7:0]   tl [3];
  int           passed = 0, total = 0, fails = 0;
  int           t2_ord [4], t2_drain [4], t3_ord [5], t5_first;

  assign req_addr = {ta[2], ta[1], ta[0]};
  assign req_len  = {tl[2], tl[1], tl[0]};

  always #5 clk_data = ~clk_data;

  mem_rd_arbiter dut (
    .clk_data(clk_data), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_stall(req_stall), .req_ready(req_ready),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
    .mem_rd_data(mem_rd_data), .mem_rd_vld(mem_rd_vld),
    .rd_data(rd_data), .rd_vld(rd_vld), .burst_done(burst_done), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_data);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req_valid = '0; req_stall = '0; mem_cmd_ready = 1'b0;
    mem_rd_vld = 1'b0; mem_rd_data = '0;
    step();
    rst_n = 1'b1;
  endtask

  // Grant edge then push edge; mem_rd_vld is a single-cycle pulse if set by caller.
  task automatic expect_grant(input int id, input logic [31:0] addr, input logic [7:0] len,
                              input string tag);
    logic [2:0] oh;
    oh = 3'b001 << id;
    step();
    mem_rd_vld = 1'b0;
    chk({tag, " req_ready"}, req_ready, oh);
    chk({tag, " cmd_valid"}, mem_cmd_valid, 1'b1);
    chk({tag, " cmd_addr"}, mem_cmd_addr, addr);
    chk({tag, " cmd_len"}, mem_cmd_len, len);
    step();
    chk({tag, " cmd_done"}, mem_cmd_valid, 1'b0);
  endtask

  task automatic beat(input logic [511:0] d, input logic [2:0] vld, input logic [2:0] bd,
                      input string tag);
    mem_rd_vld = 1'b1;
    mem_rd_data = d;
    step();
    mem_rd_vld = 1'b0;
    chk({tag, " rd_vld"}, rd_vld, vld);
    chk({tag, " burst_done"}, burst_done, bd);
    chk({tag, " rd_data"}, rd_data, d);
  endtask

  initial begin
    logic [511:0] d;
    logic [2:0] v5 [5], b5 [5];
`ifdef WEIGHT_PRIO_EN
    t2_ord = '{1, 1, 1, 1}; t2_drain = '{1, 1, 1, 1};
    t3_ord = '{1, 1, 1, 1, 1}; t5_first = 1;
`else
    t2_ord = '{0, 1, 2, 0}; t2_drain = '{1, 2, 0, 1};
    t3_ord = '{1, 2, 1, 2, 0}; t5_first = 0;
`endif
    ta = '{32'h100, 32'h200, 32'h300};
    tl = '{8'd0, 8'd0, 8'd0};
    rst_n = 1'b0;
    req_valid = '0; req_stall = '0; mem_cmd_ready = 1'b0;
    mem_rd_vld = 1'b0; mem_rd_data = '0;
    step(); step();
    chk("rst req_ready", req_ready, 3'b000);
    chk("rst cmd_valid", mem_cmd_valid, 1'b0);
    chk("rst cmd_addr", mem_cmd_addr, 32'h0);
    chk("rst cmd_len", mem_cmd_len, 8'h0);
    chk("rst rd_data", rd_data, 512'h0);
    chk("rst rd_vld", rd_vld, 3'b000);
    chk("rst burst_done", burst_done, 3'b000);
    chk("rst rsp_err", rsp_err, 1'b0);
    rst_n = 1'b1;
    step();

    // single 4-beat burst from requester 0
    ta[0] = 32'h1000; tl[0] = 8'd3; req_valid = 3'b001; mem_cmd_ready = 1'b1;
    expect_grant(0, 32'h1000, 8'd3, "t1");
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      d = {16{32'hA000_0000 + k}};
      beat(d, 3'b001, (k == 3) ? 3'b001 : 3'b000, $sformatf("t1 beat%0d", k));
    end
    step();
    chk("t1 idle rd_vld", rd_vld, 3'b000);
    chk("t1 idle burst_done", burst_done, 3'b000);

    // round-robin fill to OUTS, blocked 5th grant, then in-order drain
    reset_dut();
    ta = '{32'h100, 32'h200, 32'h300}; tl = '{8'd0, 8'd0, 8'd0};
    req_valid = 3'b111; mem_cmd_ready = 1'b1;
    for (int g = 0; g < 4; g++)
      expect_grant(t2_ord[g], ta[t2_ord[g]], 8'd0, $sformatf("t2 g%0d", g));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t2 full blocks", mem_cmd_valid, 1'b0);
    end
    d = {16{32'hB000_0000}};
    beat(d, 3'b001 << t2_ord[0], 3'b001 << t2_ord[0], "t2 pop");
    chk("t2 no grant on pop", mem_cmd_valid, 1'b0);
    step();
    chk("t2 5th cmd_valid", mem_cmd_valid, 1'b1);
    chk("t2 5th req_ready", req_ready, 3'b010);
    chk("t2 5th addr", mem_cmd_addr, 32'h200);
    req_valid = '0;
    step();
    for (int k = 0; k < 4; k++) begin
      d = {16{32'hB100_0000 + k}};
      beat(d, 3'b001 << t2_drain[k], 3'b001 << t2_drain[k], $sformatf("t2 drain%0d", k));
    end

    // stall on requester 0, then release
    reset_dut();
    req_valid = 3'b111; req_stall = 3'b001; mem_cmd_ready = 1'b1;
    for (int g = 0; g < 3; g++)
      expect_grant(t3_ord[g], ta[t3_ord[g]], 8'd0, $sformatf("t3 g%0d", g));
    req_stall = 3'b000;
    mem_rd_vld = 1'b1;
    for (int g = 3; g < 5; g++)
      expect_grant(t3_ord[g], ta[t3_ord[g]], 8'd0, $sformatf("t3 g%0d", g));
    req_valid = '0;

    // weights dropping out falls back to round-robin 2,0
    reset_dut();
    req_valid = 3'b111; mem_cmd_ready = 1'b1;
    expect_grant(t5_first, ta[t5_first], 8'd0, "t5 first");
    req_valid = 3'b101;
    expect_grant(2, 32'h300, 8'd0, "t5 g1");
    expect_grant(0, 32'h100, 8'd0, "t5 g2");
    req_valid = '0;

    // command backpressure, interleaved ordering, orphan beat
    reset_dut();
    ta[0] = 32'h4000; tl[0] = 8'd1; req_valid = 3'b001; mem_cmd_ready = 1'b0;
    step();
    chk("t4 req_ready", req_ready, 3'b001);
    chk("t4 cmd_valid", mem_cmd_valid, 1'b1);
    req_valid = '0; ta[0] = 32'h5000; tl[0] = 8'd7;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4 hold valid", mem_cmd_valid, 1'b1);
      chk("t4 hold addr", mem_cmd_addr, 32'h4000);
      chk("t4 hold len", mem_cmd_len, 8'd1);
      chk("t4 hold ready", req_ready, 3'b000);
    end
    mem_cmd_ready = 1'b1;
    step();
    chk("t4 accepted", mem_cmd_valid, 1'b0);
    ta[2] = 32'h6000; tl[2] = 8'd0; req_valid = 3'b100;
    expect_grant(2, 32'h6000, 8'd0, "t4 bias");
    tl[0] = 8'd1; req_valid = 3'b001;
    expect_grant(0, 32'h5000, 8'd1, "t4 data2");
    req_valid = '0;
    v5 = '{3'b001, 3'b001, 3'b100, 3'b001, 3'b001};
    b5 = '{3'b000, 3'b001, 3'b100, 3'b000, 3'b001};
    for (int k = 0; k < 5; k++) begin
      d = {16{32'hC000_0000 + k}};
      beat(d, v5[k], b5[k], $sformatf("t4 beat%0d", k));
    end
    mem_rd_vld = 1'b1; mem_rd_data = {16{32'hDEAD_BEEF}};
    step();
    mem_rd_vld = 1'b0;
    chk("t4 orphan rd_vld", rd_vld, 3'b000);
    chk("t4 orphan burst_done", burst_done, 3'b000);
    chk("t4 orphan rsp_err", rsp_err, 1'b1);
    step();
    chk("t4 rsp_err sticky", rsp_err, 1'b1);

    // reset mid-command clears at once; a late beat then flags rsp_err
    req_valid = 3'b001; mem_cmd_ready = 1'b0;
    step();
    chk("t6 pre cmd_valid", mem_cmd_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst cmd_valid", mem_cmd_valid, 1'b0);
    chk("t6 rst req_ready", req_ready, 3'b000);
    chk("t6 rst rsp_err", rsp_err, 1'b0);
    chk("t6 rst cmd_addr", mem_cmd_addr, 32'h0);
    req_valid = '0;
    step();
    rst_n = 1'b1;
    mem_rd_vld = 1'b1;
    step();
    mem_rd_vld = 1'b0;
    chk("t6 late beat rsp_err", rsp_err, 1'b1);
    chk("t6 late beat rd_vld", rd_vld, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
